// File: rtl/rc_servo_sd_adc_channel.sv
// One axis of the sigma-delta position ADC: comparator synchroniser, feedback
// bit, ones-counting decimator over a 2^WIN_BITS window and optional IIR smoothing.
module rc_servo_sd_adc_channel #(
    parameter int WIN_BITS     = 8,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                comp_async_i,
    output logic                pwm_pin_o,
    output logic [WIN_BITS-1:0] sample_o,
    output logic                sample_valid_o
);

    localparam int ACC_W = WIN_BITS + 1;

    logic                s1_q, s2_q, pwm_q;
    logic [WIN_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0]    ones_acc_q, ones_acc_d;
    logic [WIN_BITS-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;

    logic                terminal;
    logic [ACC_W-1:0]    raw;
    logic [WIN_BITS-1:0] raw_sat;
    logic [WIN_BITS-1:0] smoothed;

    // s1 is the only flop that sees the asynchronous pad; nothing but s2 reads it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            s1_q  <= comp_async_i;
            s2_q  <= s1_q;
            pwm_q <= s2_q;
        end
    end

    // raw includes the terminal cycle's bit, so a full window of ones reaches 2^WIN_BITS.
    always_comb begin
        terminal   = &win_cnt_q;
        raw        = ones_acc_q + ACC_W'(pwm_q);
        raw_sat    = raw[WIN_BITS] ? {WIN_BITS{1'b1}} : raw[WIN_BITS-1:0];
        win_cnt_d  = win_cnt_q + 1'b1;
        ones_acc_d = terminal ? '0 : raw;
        sample_d   = terminal ? smoothed : sample_q;
        valid_d    = terminal;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            win_cnt_q  <= '0;
            ones_acc_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            ones_acc_q <= ones_acc_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

    generate
        if (SMOOTH_SHIFT > 0) begin : g_iir
            localparam int F_W = WIN_BITS + SMOOTH_SHIFT;

            logic [F_W-1:0] f_q, f_d;
            logic [F_W-1:0] f_step;
            logic           first_q, first_d;

            // f settles at raw<<K for a constant input, so it never exceeds (2^W-1)<<K.
            always_comb begin
                f_step  = f_q - (f_q >> SMOOTH_SHIFT) + F_W'(raw_sat);
                f_d     = f_q;
                first_d = first_q;
                if (terminal) begin
                    f_d     = first_q ? {raw_sat, {SMOOTH_SHIFT{1'b0}}} : f_step;
                    first_d = 1'b0;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    f_q     <= '0;
                    first_q <= 1'b1;
                end else begin
                    f_q     <= f_d;
                    first_q <= first_d;
                end
            end

            assign smoothed = f_d[F_W-1:SMOOTH_SHIFT];
        end else begin : g_bypass
            assign smoothed = raw_sat;
        end
    endgenerate

    assign pwm_pin_o      = pwm_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule
